osc_scheduler: RTL
==================

// Module: osc_scheduler
//
// PURPOSE
// Sequences the single shared wave-generator core across all oscillators once per sample period.
// Snapshots control_unit's wave_gens array into a shadow copy at a sample boundary, so a frame never
// mixes old and new config. Issues one request per oscillator over a valid/ready handshake and sums
// the returned samples. Emits one mixed sample per sample_tick.
// Sits between control_unit (config source), the wavegen core (datapath) and the output mixer.
//
// PARAMETERS
// N_OSC     `N_OSCILLATORS  number of oscillators scheduled per sample period
// SAMPLE_W  24              width of signed sample returned by core
// ACC_W     SAMPLE_W+$clog2(N_OSC)  width of signed mix accumulator/output (derived, not overridable)
//
// PORTS
// clk           in   1                  system clock
// rstn          in   1                  reset, synchronous, active-low
// sample_tick   in   1                  1-cycle pulse, start of sample period
// cfg_update    in   1                  control_unit output_update; new wave_gens valid
// wave_gens_in  in   wavegen_t[N_OSC]   live config from control_unit
// osc_valid     out  1                  request to core valid
// osc_ready     in   1                  core accepts request
// osc_idx       out  $clog2(N_OSC)      oscillator index of request
// osc_cfg       out  wavegen_t          shadow config of osc_idx
// res_valid     in   1                  core result valid (results return in issue order)
// res_sample    in   SAMPLE_W signed    core result
// mix_valid     out  1                  1-cycle pulse, mix_out valid
// mix_out       out  ACC_W signed       sum of N_OSC results for the period
// overrun       out  1                  sticky: tick arrived while busy
// proto_err     out  1                  sticky: unexpected res_valid
//
// BEHAVIOUR
// - Reset (rstn=0 at posedge): state=IDLE, osc_valid=0, osc_idx=0, mix_valid=0, mix_out=0,
//   overrun=0, proto_err=0, pending=0, issue/result counters=0, shadow config all-zero bits.
//   Reset mid-frame abandons the frame; no mix_valid. Core results arriving afterwards are ignored.
// - cfg_update sets pending (any state). Shadow is copied from wave_gens_in only on frame start.
// - IDLE: on sample_tick: if pending or cfg_update this cycle, shadow<=wave_gens_in, pending<=0.
//   Then acc<=0, counters<=0, osc_idx<=0, go ISSUE. A cfg_update coincident with the tick is applied.
// - ISSUE: osc_valid=1, osc_cfg=shadow[osc_idx]. osc_idx/osc_cfg stay stable until osc_ready.
//   Transfer occurs when osc_valid&&osc_ready; osc_idx increments.
//   After transfer of idx N_OSC-1, osc_valid drops next cycle and the FSM goes to DRAIN.
// - Results are accepted in both ISSUE and DRAIN: acc+=sign-extended res_sample, res_cnt++.
// - When the N_OSC-th result is accepted (ISSUE or DRAIN), mix_out<=acc+res_sample,
//   mix_valid=1 next cycle for exactly one cycle. The FSM goes to IDLE the same cycle.
//   Latency is counted from the last result to mix_valid: 1 cycle.
// - ACC_W guarantees no overflow: worst case N_OSC * -2^(SAMPLE_W-1) fits. No saturation.
// - sample_tick outside IDLE: ignored, overrun<=1. Current frame completes normally.
// - res_valid in IDLE, or beyond N_OSC results: result discarded, proto_err<=1.
// - pending set during a frame is held until the next tick. Multiple cfg_updates coalesce.
// - Sticky flags clear only on reset.
//
// STRUCTURE
// - shape_pkg: osc_sched_state_t enum {IDLE, ISSUE, DRAIN}. Add to shape_pkg beside wavegen_t.
// - Constants: `N_OSCILLATORS from constants.svh; add `SAMPLE_W there.
// - Single module, no sub-module: one FSM, two counters, shadow register array, accumulator.
// - Shadow is a plain register array. The osc_cfg mux is indexed by osc_idx.
//
// TESTING
// - Basic frame: N_OSC=4, osc_ready=1, results 100,200,-50,7 -> mix_valid one pulse, mix_out=257.
// - Backpressure: osc_ready low 3 cycles at idx 1 -> osc_idx=1 and osc_cfg held stable;
//   exactly 4 transfers; mix_out correct.
// - Config atomicity: cfg_update mid-frame with new wave_gens_in -> current frame's osc_cfg uses
//   the old shadow; the next frame's osc_cfg equals the new config.
//   cfg_update coincident with tick -> new config is used immediately.
// - Overrun/proto: tick during ISSUE -> overrun=1, the frame still completes with one mix_valid.
//   res_valid in IDLE -> proto_err=1, acc unaffected.
// - Extremes: SAMPLE_W=24, all 4 results=-8388608 -> mix_out=-33554432, no wrap.
// - Reset mid-DRAIN after 2 results -> all outputs at reset values, no mix_valid.
//   A subsequent tick runs a clean frame with a zero shadow unless cfg_update was seen.

Source files
------------

// File: rtl/osc_scheduler_pkg.sv
// Shared types and constants for the oscillator scheduler slice: the
// per-oscillator wave-generator config record, scheduler FSM states and
// default sizing used by control_unit, the wavegen core and the mixer.
package osc_scheduler_pkg;

  // Number of oscillators sequenced through the shared core each sample period
  localparam int N_OSCILLATORS = 4;
  // Width of the signed sample produced by the wavegen core
  localparam int SAMPLE_WIDTH  = 24;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_shape_t;

  // One oscillator's generator configuration as published by control_unit
  typedef struct packed {
    logic        enable;
    wave_shape_t shape;
    logic [23:0] phase_inc;
    logic [15:0] amplitude;
  } wavegen_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } osc_sched_state_t;

  // Index width that stays legal for a single-oscillator build
  function automatic int osc_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osc_scheduler.sv
// Once per sample period: snapshots the live oscillator configs into a
// shadow copy, issues one request per oscillator to the shared wavegen core
// over valid/ready, sums the in-order results and emits a single mixed sample.
// The accumulator is wide enough that the sum of N_OSC full-scale negative
// samples cannot wrap, so no saturation is needed.
module osc_scheduler
  import osc_scheduler_pkg::*;
#(
  parameter int N_OSC    = N_OSCILLATORS,
  parameter int SAMPLE_W = SAMPLE_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      sample_tick,
  input  logic                                      cfg_update,
  input  wavegen_t [N_OSC-1:0]                      wave_gens_in,
  output logic                                      osc_valid,
  input  logic                                      osc_ready,
  output logic [osc_idx_width(N_OSC)-1:0]           osc_idx,
  output wavegen_t                                  osc_cfg,
  input  logic                                      res_valid,
  input  logic signed [SAMPLE_W-1:0]                res_sample,
  output logic                                      mix_valid,
  output logic signed [SAMPLE_W+$clog2(N_OSC)-1:0]  mix_out,
  output logic                                      overrun,
  output logic                                      proto_err
);

  localparam int ACC_W = SAMPLE_W + $clog2(N_OSC);
  localparam int IDX_W = osc_idx_width(N_OSC);
  localparam int CNT_W = $clog2(N_OSC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OSC - 1);
  localparam logic [CNT_W-1:0] LAST_RES = CNT_W'(N_OSC - 1);

  osc_sched_state_t        state_reg;
  logic                    pending_reg;
  logic [CNT_W-1:0]        res_cnt_reg;
  logic signed [ACC_W-1:0] acc_reg;
  wavegen_t                shadow_reg [N_OSC];

  logic                    frame_start;
  logic                    shadow_load;
  logic                    xfer;
  logic                    res_take;
  logic                    last_res;
  logic signed [ACC_W-1:0] res_ext;

  // A frame starts only from IDLE; the shadow reloads only if new config
  // was announced since the last load (including on this very cycle).
  assign frame_start = (state_reg == IDLE) && sample_tick;
  assign shadow_load = frame_start && (pending_reg || cfg_update);

  // osc_valid is only ever high in ISSUE, so this is the request transfer
  assign xfer     = osc_valid && osc_ready;
  // Results count only while a frame is open; the FSM leaves for IDLE on the
  // N_OSC-th result, so an open frame never sees more than N_OSC of them
  assign res_take = res_valid && (state_reg != IDLE);
  assign last_res = res_take && (res_cnt_reg == LAST_RES);
  assign res_ext  = ACC_W'(res_sample);

  // The request payload always reflects the frame's frozen config
  assign osc_cfg = shadow_reg[osc_idx];

  // Shadow config: copied atomically from the live array only at a frame start
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_OSC; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (shadow_load) begin
      for (int i = 0; i < N_OSC; i++) begin
        shadow_reg[i] <= wave_gens_in[i];
      end
    end
  end

  // Frame sequencing FSM: request issue, result accumulation, mix output and sticky flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      res_cnt_reg <= '0;
      acc_reg     <= '0;
      osc_valid   <= 1'b0;
      osc_idx     <= '0;
      mix_valid   <= 1'b0;
      mix_out     <= '0;
      overrun     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;

      // Config announcements coalesce until the next frame start consumes them
      if (cfg_update) begin
        pending_reg <= 1'b1;
      end

      if (sample_tick && (state_reg != IDLE)) begin
        overrun <= 1'b1;
      end

      // A result with no open frame is dropped without touching the accumulator
      if (res_valid && (state_reg == IDLE)) begin
        proto_err <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (sample_tick) begin
            // Clearing here also absorbs a cfg_update coincident with the tick,
            // since that update is the one being loaded right now
            pending_reg <= 1'b0;
            acc_reg     <= '0;
            res_cnt_reg <= '0;
            osc_idx     <= '0;
            osc_valid   <= 1'b1;
            state_reg   <= ISSUE;
          end
        end

        ISSUE: begin
          if (xfer) begin
            if (osc_idx == LAST_IDX) begin
              osc_valid <= 1'b0;
              state_reg <= DRAIN;
            end else begin
              osc_idx <= osc_idx + IDX_W'(1);
            end
          end
        end

        DRAIN: begin
          // Waiting only for the remaining results
        end

        default: begin
          osc_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase

      // Placed after the case so the final result's return to IDLE wins
      if (res_take) begin
        acc_reg     <= acc_reg + res_ext;
        res_cnt_reg <= res_cnt_reg + CNT_W'(1);
        if (last_res) begin
          mix_out   <= acc_reg + res_ext;
          mix_valid <= 1'b1;
          osc_valid <= 1'b0;
          state_reg <= IDLE;
        end
      end
    end
  end

endmodule
